// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide unit with pipeline stall control.
// Shared shift-add multiplier / restoring divider, one iteration per clock.
module muldiv_sequencer #(
   parameter int unsigned WIDTH  = 32,
   parameter logic [4:0]  OP_MUL = 5'd11
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [4:0]       ALUOP,
   input  logic [WIDTH-1:0] OPERAND1,
   input  logic [WIDTH-1:0] OPERAND2,
   input  logic             ABORT,
   output logic             STALL,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
   typedef enum logic [2:0] {
      OP_MULL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   state_t                 state_q, state_d;
   op_t                    op_q, op_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   neg_q, neg_d;
   logic                   spec_q, spec_d;
   logic [2*WIDTH-1:0]     x_q, x_d;
   logic [WIDTH-1:0]       y_q, y_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]       result_q, result_d;

   logic [4:0]       op_off;
   logic             is_md;
   op_t              op_in;
   logic             s1, s2, neg_in, div0, ovf;
   logic [WIDTH-1:0] mag1, mag2, spec_val;
   logic [WIDTH:0]   rem_sh, trial;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] quo_s, rem_s, fix_val;

   assign op_off = ALUOP - OP_MUL;
   assign is_md  = (ALUOP >= OP_MUL) && (op_off < 5'd8);
   assign op_in  = op_t'(op_off[2:0]);

   always_comb begin
      s1 = OPERAND1[WIDTH-1] &&
           (op_in inside {OP_MULL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      s2 = OPERAND2[WIDTH-1] && (op_in inside {OP_MULL, OP_MULH, OP_DIV, OP_REM});
      mag1 = s1 ? ('0 - OPERAND1) : OPERAND1;
      mag2 = s2 ? ('0 - OPERAND2) : OPERAND2;
      neg_in = (op_in == OP_REM) ? s1 : (s1 ^ s2);
      div0 = op_in[2] && (OPERAND2 == '0);
      ovf  = (op_in inside {OP_DIV, OP_REM}) && (OPERAND1 == MIN_NEG) && (OPERAND2 == '1);
      spec_val = '0;
      if (div0)
         spec_val = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : OPERAND1;
      else if (op_in == OP_DIV)
         spec_val = MIN_NEG;
   end

   // Divide step: remainder lives in acc_q low half, dividend/quotient in x_q low half.
   assign rem_sh = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, y_q};

   always_comb begin
      prod_s = neg_q ? ('0 - acc_q) : acc_q;
      quo_s  = neg_q ? ('0 - x_q[WIDTH-1:0]) : x_q[WIDTH-1:0];
      rem_s  = neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      if (!op_q[2])
         fix_val = (op_q == OP_MULL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
      else
         fix_val = (op_q inside {OP_DIV, OP_DIVU}) ? quo_s : rem_s;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      spec_d   = spec_q;
      x_d      = x_q;
      y_d      = y_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (START && is_md) begin
               op_d   = op_in;
               x_d    = {{WIDTH{1'b0}}, mag1};
               y_d    = mag2;
               cnt_d  = '0;
               neg_d  = neg_in;
               spec_d = div0 || ovf;
               // Special divides park their answer in acc and pass through FIX for one cycle.
               if (div0 || ovf) begin
                  acc_d   = {{WIDTH{1'b0}}, spec_val};
                  state_d = S_FIX;
               end else begin
                  acc_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[2]) begin
                  acc_d = {{WIDTH{1'b0}}, trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]};
                  x_d   = {x_q[2*WIDTH-2:0], ~trial[WIDTH]};
               end else begin
                  acc_d = acc_q + (y_q[0] ? x_q : '0);
                  x_d   = x_q << 1;
                  y_d   = y_q >> 1;
               end
               if (cnt_q == CNT_LAST)
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else begin
               result_d = spec_q ? acc_q[WIDTH-1:0] : fix_val;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MULL;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         spec_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         spec_q   <= spec_d;
         x_q      <= x_d;
         y_q      <= y_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign BUSY   = (state_q == S_CALC) || (state_q == S_FIX);
   assign DONE   = (state_q == S_DONE);
   assign STALL  = BUSY || (START && is_md);
   assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

   localparam logic [4:0] A_MUL = 5'd11, A_MULH = 5'd12, A_MULHSU = 5'd13, A_MULHU = 5'd14;
   localparam logic [4:0] A_DIV = 5'd15, A_DIVU = 5'd16, A_REM = 5'd17, A_REMU = 5'd18;

   logic        CLK = 1'b0;
   logic        RESET, START, ABORT;
   logic [4:0]  ALUOP;
   logic [31:0] OPERAND1, OPERAND2;
   logic        STALL, BUSY, DONE;
   logic [31:0] RESULT;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   muldiv_sequencer #(.WIDTH(32), .OP_MUL(5'd11)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .ALUOP(ALUOP),
      .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .ABORT(ABORT),
      .STALL(STALL), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   // Latency k: DONE first seen after edge t0+k, where t0 samples START.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls, output logic [31:0] res);
      int k;
      @(negedge CLK);
      START = 1'b1; ALUOP = op; OPERAND1 = a; OPERAND2 = b;
      #1 stalls = STALL ? 1 : 0;
      @(negedge CLK);
      START = 1'b0; ALUOP = 5'd0;
      k = 0;
      while (DONE !== 1'b1 && k < 200) begin
         if (STALL) stalls++;
         @(negedge CLK);
         k++;
      end
      lat = k;
      res = RESULT;
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; ABORT = 1'b0; ALUOP = 5'd0; OPERAND1 = '0; OPERAND2 = '0;
      @(negedge CLK); @(negedge CLK);
      checks++;
      if ({STALL, BUSY, DONE, RESULT} !== 35'd0)
         $display("FAIL reset_state got stall=%b busy=%b done=%b result=%h exp all zero",
                  STALL, BUSY, DONE, RESULT);
      if ({STALL, BUSY, DONE, RESULT} !== 35'd0) errors++;
      RESET = 1'b0;
   endtask

   task automatic test_mul();
      logic [4:0]  ops [6] = '{A_MUL, A_MULHU, A_MULH, A_MULHSU, A_MULH, A_MUL};
      logic [31:0] as  [6] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h3};
      logic [31:0] bs  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h4};
      logic [31:0] ex  [6] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h40000000, 32'hC};
      int lat, stalls;
      logic [31:0] res;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], lat, stalls, res);
         checks++;
         if (res !== ex[i]) begin
            errors++;
            $display("FAIL mul_result op=%0d got=%h exp=%h", ops[i], res, ex[i]);
         end
         checks++;
         if (lat !== 33) begin
            errors++;
            $display("FAIL mul_latency op=%0d got=%0d exp=33", ops[i], lat);
         end
         checks++;
         if (STALL !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL mul_done_cycle stall=%b busy=%b exp 0 0", STALL, BUSY);
         end
         if (i == 0) begin
            checks++;
            if (stalls !== 34) begin
               errors++;
               $display("FAIL mul_stall_cycles got=%0d exp=34", stalls);
            end
         end
      end
   endtask

   task automatic test_div();
      logic [4:0]  ops [5] = '{A_DIV, A_REM, A_DIVU, A_REMU, A_DIV};
      logic [31:0] as  [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000};
      logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd2};
      logic [31:0] ex  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hC0000000};
      int lat, stalls;
      logic [31:0] res;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], lat, stalls, res);
         checks++;
         if (res !== ex[i]) begin
            errors++;
            $display("FAIL div_result op=%0d got=%h exp=%h", ops[i], res, ex[i]);
         end
         checks++;
         if (lat !== 33) begin
            errors++;
            $display("FAIL div_latency op=%0d got=%0d exp=33", ops[i], lat);
         end
      end
   endtask

   task automatic test_special();
      logic [4:0]  ops [5] = '{A_DIV, A_REMU, A_DIV, A_REM, A_DIVU};
      logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9};
      logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
      logic [31:0] ex  [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF};
      int lat, stalls;
      logic [31:0] res;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], lat, stalls, res);
         checks++;
         if (res !== ex[i]) begin
            errors++;
            $display("FAIL special_result op=%0d got=%h exp=%h", ops[i], res, ex[i]);
         end
         checks++;
         if (lat !== 1) begin
            errors++;
            $display("FAIL special_latency op=%0d got=%0d exp=1", ops[i], lat);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] prev;
      logic        seen;
      int          k;
      prev = RESULT;
      seen = 1'b0;
      @(negedge CLK);
      START = 1'b1; ALUOP = A_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
      @(negedge CLK);
      START = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (DONE) seen = 1'b1;
         @(negedge CLK);
      end
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || seen) begin
         errors++;
         $display("FAIL abort_state busy=%b done=%b early_done=%b exp 0 0 0", BUSY, DONE, seen);
      end
      checks++;
      if (RESULT !== prev) begin
         errors++;
         $display("FAIL abort_result got=%h exp=%h", RESULT, prev);
      end
      START = 1'b1; ALUOP = A_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd4;
      @(negedge CLK);
      START = 1'b0;
      k = 0;
      while (DONE !== 1'b1 && k < 200) begin
         @(negedge CLK);
         k++;
      end
      checks++;
      if (RESULT !== 32'd12 || k !== 33) begin
         errors++;
         $display("FAIL abort_then_mul got=%h lat=%0d exp=0000000c lat=33", RESULT, k);
      end
   endtask

   task automatic test_reset_midcalc();
      @(negedge CLK);
      START = 1'b1; ALUOP = A_MUL; OPERAND1 = 32'd5; OPERAND2 = 32'd6;
      @(negedge CLK);
      START = 1'b0;
      repeat (5) @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      checks++;
      if ({STALL, BUSY, DONE, RESULT} !== 35'd0) begin
         errors++;
         $display("FAIL reset_midcalc got stall=%b busy=%b done=%b result=%h exp all zero",
                  STALL, BUSY, DONE, RESULT);
      end
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic test_ignored_start();
      logic bad;
      bad = 1'b0;
      @(negedge CLK);
      START = 1'b1; ALUOP = 5'd1; OPERAND1 = 32'd1; OPERAND2 = 32'd2;
      #1;
      checks++;
      if (STALL !== 1'b0) begin
         errors++;
         $display("FAIL nonm_stall got=%b exp=0", STALL);
      end
      repeat (3) begin
         @(negedge CLK);
         if (BUSY !== 1'b0 || DONE !== 1'b0) bad = 1'b1;
      end
      START = 1'b0;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL nonm_ignored busy=%b done=%b exp 0 0", BUSY, DONE);
      end
   endtask

   task automatic test_start_while_busy();
      int k;
      @(negedge CLK);
      START = 1'b1; ALUOP = A_MUL; OPERAND1 = 32'h7; OPERAND2 = 32'hFFFFFFFD;
      @(negedge CLK);
      START = 1'b0;
      k = 0;
      while (DONE !== 1'b1 && k < 200) begin
         START = (k == 5);
         if (k == 5) begin
            ALUOP = A_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
         end
         @(negedge CLK);
         k++;
      end
      START = 1'b0;
      checks++;
      if (RESULT !== 32'hFFFFFFEB || k !== 33) begin
         errors++;
         $display("FAIL busy_restart got=%h lat=%0d exp=ffffffeb lat=33", RESULT, k);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      @(negedge CLK);
      START = 1'b1; ALUOP = A_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd4;
      @(negedge CLK);
      START = 1'b0;
      k = 0;
      while (DONE !== 1'b1 && k < 200) begin
         @(negedge CLK);
         k++;
      end
      START = 1'b1; ALUOP = A_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
      #1;
      checks++;
      if (DONE !== 1'b1 || STALL !== 1'b1 || RESULT !== 32'd12) begin
         errors++;
         $display("FAIL b2b_done_cycle done=%b stall=%b result=%h exp 1 1 0000000c", DONE, STALL, RESULT);
      end
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || STALL !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap busy=%b stall=%b exp 0 1", BUSY, STALL);
      end
      @(negedge CLK);
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept busy=%b exp 1", BUSY);
      end
      k = 0;
      while (DONE !== 1'b1 && k < 200) begin
         @(negedge CLK);
         k++;
      end
      checks++;
      if (RESULT !== 32'd14 || k !== 33) begin
         errors++;
         $display("FAIL b2b_second got=%h lat=%0d exp=0000000e lat=33", RESULT, k);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_abort();
      test_reset_midcalc();
      test_ignored_start();
      test_start_while_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
